// File: rtl/period_meter.sv
// Measures the period of an asynchronous input in sampling-clock cycles.
// Publishes the last period, an update pulse, a valid flag and a stopped-input timeout.
module period_meter #(
  parameter int              CNT_W       = 32,
  parameter int              SYNC_STAGES = 2,
  parameter longint unsigned MAX_PERIOD  = 65535
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic             PWRDWN,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_length,
  output logic             period_update,
  output logic             period_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_d_q;
  logic                   sig_s;
  logic                   rise;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       len_q;
  logic                   upd_q;
  logic                   vld_q;
  logic                   tmo_q;

  // Synchronizer and edge-delay flop keep running through power-down.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sync_q  <= '0;
      sig_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d_q <= sig_s;
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d_q;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      upd_q   <= 1'b0;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (PWRDWN) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        len_q   <= '0;
        vld_q   <= 1'b0;
        tmo_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise) begin
              cnt_q   <= ONE;
              state_q <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            // An edge landing on the MAX_PERIOD cycle is still a valid measurement.
            if (rise) begin
              len_q <= cnt_q;
              upd_q <= 1'b1;
              vld_q <= 1'b1;
              tmo_q <= 1'b0;
              cnt_q <= ONE;
            end else if (cnt_q == MAX_C) begin
              len_q   <= '0;
              vld_q   <= 1'b0;
              tmo_q   <= 1'b1;
              state_q <= ST_TIMEOUT;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
          ST_TIMEOUT: begin
            // Counter stays saturated; timeout holds until the next real update.
            if (rise) begin
              cnt_q   <= ONE;
              state_q <= ST_MEASURE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign period_length = len_q;
  assign period_update = upd_q;
  assign period_valid  = vld_q;
  assign timeout       = tmo_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: directed scenarios plus random waveforms,
// compared every cycle against a timestamp-based reference model.
module tb_period_meter;

  localparam int CNT_W = 32;
  localparam int S     = 2;
  localparam int MAXP  = 100;

  logic             clk = 1'b0;
  logic             RST_N;
  logic             PWRDWN;
  logic             sig_in;
  logic [CNT_W-1:0] period_length;
  logic             period_update;
  logic             period_valid;
  logic             timeout;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(S), .MAX_PERIOD(MAXP)) dut (
    .clk           (clk),
    .RST_N         (RST_N),
    .PWRDWN        (PWRDWN),
    .sig_in        (sig_in),
    .period_length (period_length),
    .period_update (period_update),
    .period_valid  (period_valid),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: sig_in values as sampled at each clock edge since reset.
  // A rise is seen S edges after sig_in is first sampled high; a period is the
  // distance in edges between consecutive rises, abandoned after MAXP edges.
  bit               samp[$];
  logic [CNT_W-1:0] m_len;
  logic             m_vld, m_upd, m_tmo;
  bit               have_last;
  int               last;

  always @(posedge clk or negedge RST_N) begin
    int e;
    bit r;
    if (!RST_N) begin
      samp.delete();
      m_len     <= '0;
      m_vld     <= 1'b0;
      m_upd     <= 1'b0;
      m_tmo     <= 1'b0;
      have_last <= 1'b0;
      last      <= 0;
    end else begin
      samp.push_back(sig_in);
      e = samp.size() - 1;
      r = (e >= S) && samp[e-S] && ((e - S == 0) || !samp[e-S-1]);
      m_upd <= 1'b0;
      if (PWRDWN) begin
        m_len     <= '0;
        m_vld     <= 1'b0;
        m_tmo     <= 1'b0;
        have_last <= 1'b0;
      end else if (r) begin
        if (have_last) begin
          m_len <= CNT_W'(e - last);
          m_vld <= 1'b1;
          m_upd <= 1'b1;
          m_tmo <= 1'b0;
        end
        have_last <= 1'b1;
        last      <= e;
      end else if (have_last && (e - last == MAXP)) begin
        m_len     <= '0;
        m_vld     <= 1'b0;
        m_tmo     <= 1'b1;
        have_last <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // p: period, hi: high cycles per period (0 = held low), n: cycles,
  // PWRDWN asserted for cycle indices [pf, pt).
  task automatic run(input int p, input int hi, input int n, input int pf, input int pt);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      sig_in = ((c % p) < hi);
      PWRDWN = (c >= pf && c < pt);
    end
  endtask

  initial begin
    int p, hi, n, pf, pt;
    RST_N  = 1'b0;
    PWRDWN = 1'b0;
    sig_in = 1'b0;
    #12;
    chk("rst_len", 64'(period_length), 64'd0);
    chk("rst_vld", 64'(period_valid), 64'd0);
    chk("rst_upd", 64'(period_update), 64'd0);
    chk("rst_tmo", 64'(timeout), 64'd0);
    @(negedge clk);
    RST_N  = 1'b1;
    chk_en = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (RST_N && chk_en)
          chk("cycle", 64'({period_length, period_valid, period_update, timeout}),
                       64'({m_len, m_vld, m_upd, m_tmo}));
      end
    join_none

    // Steady 10, then change to 25.
    run(10, 5, 80, -1, -1);
    @(negedge clk);
    chk("steady_len", 64'(period_length), 64'd10);
    chk("steady_tmo", 64'(timeout), 64'd0);
    run(25, 12, 125, -1, -1);
    @(negedge clk);
    chk("chg_len", 64'(period_length), 64'd25);

    // Stop, time out, recover at 12.
    run(10, 5, 40, -1, -1);
    run(10, 0, 130, -1, -1);
    @(negedge clk);
    chk("tmo_flag", 64'(timeout), 64'd1);
    chk("tmo_vld", 64'(period_valid), 64'd0);
    chk("tmo_len", 64'(period_length), 64'd0);
    run(12, 6, 60, -1, -1);
    @(negedge clk);
    chk("rec_len", 64'(period_length), 64'd12);
    chk("rec_tmo", 64'(timeout), 64'd0);

    // Boundary: exactly MAXP apart, then MAXP+1 apart.
    run(MAXP, 50, 3 * MAXP, -1, -1);
    @(negedge clk);
    chk("bnd_len", 64'(period_length), 64'(MAXP));
    chk("bnd_tmo", 64'(timeout), 64'd0);
    run(MAXP + 1, 50, 3 * (MAXP + 1), -1, -1);
    @(negedge clk);
    chk("bnd1_vld", 64'(period_valid), 64'd0);

    // Power-down in the middle of a period-10 stream.
    run(10, 5, 40, -1, -1);
    run(10, 5, 60, 23, 28);
    @(negedge clk);
    chk("pd_len", 64'(period_length), 64'd10);

    // Asynchronous reset pulse between clock edges.
    run(10, 5, 35, -1, -1);
    chk("pre_rst_vld", 64'(period_valid), 64'd1);
    @(posedge clk);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_len", 64'(period_length), 64'd0);
    chk("arst_vld", 64'(period_valid), 64'd0);
    #1 RST_N = 1'b1;
    run(10, 5, 40, -1, -1);

    // Minimum period.
    run(2, 1, 40, -1, -1);
    @(negedge clk);
    chk("min_len", 64'(period_length), 64'd2);

    // Random segments, occasionally silent or powered down.
    for (int k = 0; k < 25; k++) begin
      p  = $urandom_range(2, MAXP + 10);
      hi = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, p - 1);
      n  = $urandom_range(2 * p, 6 * p);
      pf = -1;
      pt = -1;
      if ($urandom_range(0, 4) == 0) begin
        pf = $urandom_range(0, n - 1);
        pt = pf + $urandom_range(1, 8);
      end
      run(p, hi, n, pf, pt);
    end
    @(negedge clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
